// File: rtl/sym2b_byte_packer.sv
// sym2b_byte_packer
//   Hunts for byte alignment in a stream of 2-bit symbols by matching a
//   sync word, then packs four consecutive symbols (first symbol in [7:6])
//   into an 8-bit data word. Sync words are consumed internally. Lock is
//   dropped when more than MAX_GAP data words arrive without a sync word.
//
// Ports
//   clk         rising-edge clock
//   reset_L     asynchronous active-low reset
//   data_in     2-bit symbol from the upstream mux
//   valid_in    data_in carries a valid symbol this cycle
//   data_out    last packed data word, held between pulses
//   valid_out   one-cycle pulse when data_out is updated
//   locked      high while aligned
//   sync_pulse  one-cycle pulse per detected sync word
//   loss_pulse  one-cycle pulse when lock is dropped on gap timeout
module sym2b_byte_packer #(
    parameter logic [7:0]  SYNC_WORD = 8'hBC,
    parameter int unsigned MAX_GAP   = 8
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [1:0] data_in,
    input  logic       valid_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       locked,
    output logic       sync_pulse,
    output logic       loss_pulse
);

    localparam logic [7:0] GAP_LIMIT = 8'(MAX_GAP);

    typedef enum logic {
        SEARCH,
        ALIGNED
    } state_t;

    state_t     state, state_nx;
    logic [7:0] shift, shift_nx;
    logic [1:0] sym_cnt, sym_cnt_nx;
    logic [7:0] gap_cnt, gap_nx;
    logic [7:0] data_nx;
    logic       valid_nx, sync_nx, loss_nx;

    logic [7:0] next_shift;
    logic       is_sync;
    logic       word_done;

    assign next_shift = {shift[5:0], data_in};
    assign is_sync    = (next_shift == SYNC_WORD);
    assign word_done  = (sym_cnt == 2'd3);

    // State register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= SEARCH;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (valid_in) begin
            case (state)
                SEARCH: begin
                    if (is_sync) begin
                        state_nx = ALIGNED;
                    end
                end
                ALIGNED: begin
                    if (word_done && !is_sync && gap_cnt >= GAP_LIMIT) begin
                        state_nx = SEARCH;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    // Datapath and output next-values; everything lands in registers below
    always_comb begin
        shift_nx   = shift;
        sym_cnt_nx = sym_cnt;
        gap_nx     = gap_cnt;
        data_nx    = data_out;
        valid_nx   = 1'b0;
        sync_nx    = 1'b0;
        loss_nx    = 1'b0;
        if (valid_in) begin
            shift_nx = next_shift;
            case (state)
                SEARCH: begin
                    if (is_sync) begin
                        sync_nx    = 1'b1;
                        sym_cnt_nx = 2'd0;
                        gap_nx     = '0;
                    end
                end
                ALIGNED: begin
                    sym_cnt_nx = sym_cnt + 2'd1;
                    if (word_done) begin
                        if (is_sync) begin
                            sync_nx = 1'b1;
                            gap_nx  = '0;
                        end else if (gap_cnt < GAP_LIMIT) begin
                            data_nx  = next_shift;
                            valid_nx = 1'b1;
                            gap_nx   = gap_cnt + 8'd1;
                        end else begin
                            // Timed-out word is dropped; the window restarts
                            // empty so the hunt begins from a clean slate.
                            loss_nx  = 1'b1;
                            shift_nx = '0;
                            gap_nx   = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            shift      <= '0;
            sym_cnt    <= '0;
            gap_cnt    <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            sync_pulse <= 1'b0;
            loss_pulse <= 1'b0;
        end else begin
            shift      <= shift_nx;
            sym_cnt    <= sym_cnt_nx;
            gap_cnt    <= gap_nx;
            data_out   <= data_nx;
            valid_out  <= valid_nx;
            sync_pulse <= sync_nx;
            loss_pulse <= loss_nx;
        end
    end

    assign locked = (state == ALIGNED);

endmodule

// File: tb/tb_sym2b_byte_packer.sv
// Randomized self-checking bench for sym2b_byte_packer against a
// queue-based reference model.
module tb_sym2b_byte_packer;

    localparam logic [7:0]  SYNC    = 8'hBC;
    localparam int unsigned MAX_GAP = 8;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [1:0] data_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out, locked, sync_pulse, loss_pulse;

    int checks = 0;
    int errors = 0;

    sym2b_byte_packer #(
        .SYNC_WORD (SYNC),
        .MAX_GAP   (MAX_GAP)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .locked     (locked),
        .sync_pulse (sync_pulse),
        .loss_pulse (loss_pulse)
    );

    always #5 clk = ~clk;

    // Reference model
    bit         m_aligned;
    int         m_window[$];
    int         m_word[$];
    int         m_gap;
    logic [7:0] m_data;
    bit         m_valid, m_sync, m_loss;

    function automatic logic [7:0] word_val(input int q[$]);
        int v = 0;
        for (int i = 0; i < 4; i++) v += q[i] * (1 << (2 * (3 - i)));
        return 8'(v);
    endfunction

    task automatic model_reset();
        m_aligned = 0;
        m_window  = '{0, 0, 0, 0};
        m_word    = {};
        m_gap     = 0;
        m_data    = 8'h00;
        m_valid   = 0;
        m_sync    = 0;
        m_loss    = 0;
    endtask

    task automatic model_step(input int sym, input bit v);
        logic [7:0] w;
        m_valid = 0;
        m_sync  = 0;
        m_loss  = 0;
        if (!v) return;
        if (!m_aligned) begin
            m_window.push_back(sym);
            void'(m_window.pop_front());
            if (word_val(m_window) == SYNC) begin
                m_aligned = 1;
                m_sync    = 1;
                m_word    = {};
                m_gap     = 0;
            end
        end else begin
            m_word.push_back(sym);
            if (m_word.size() == 4) begin
                w      = word_val(m_word);
                m_word = {};
                if (w == SYNC) begin
                    m_sync = 1;
                    m_gap  = 0;
                end else if (m_gap < int'(MAX_GAP)) begin
                    m_data  = w;
                    m_valid = 1;
                    m_gap++;
                end else begin
                    m_loss    = 1;
                    m_aligned = 0;
                    m_window  = '{0, 0, 0, 0};
                    m_gap     = 0;
                end
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".data"},   data_out,          m_data);
        check_val({tag, ".valid"},  8'(valid_out),     8'(m_valid));
        check_val({tag, ".locked"}, 8'(locked),        8'(m_aligned));
        check_val({tag, ".sync"},   8'(sync_pulse),    8'(m_sync));
        check_val({tag, ".loss"},   8'(loss_pulse),    8'(m_loss));
    endtask

    int n_valid, n_sync, n_loss;

    // One clock: drive at negedge, compare 1ns after the rising edge.
    task automatic step(input int sym, input bit v, input string tag);
        @(negedge clk);
        data_in  = 2'(sym);
        valid_in = v;
        @(posedge clk);
        #1;
        if (!reset_L) model_reset();
        else          model_step(sym, v);
        check_outputs(tag);
        n_valid += int'(valid_out);
        n_sync  += int'(sync_pulse);
        n_loss  += int'(loss_pulse);
    endtask

    task automatic send(input int sym, input int max_stall, input string tag);
        int s = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
        for (int i = 0; i < s; i++) step(int'($urandom_range(0, 3)), 1'b0, tag);
        step(sym, 1'b1, tag);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_stall, input string tag);
        logic [7:0] t = b;
        for (int i = 0; i < 4; i++) send(int'(t[7 - 2*i -: 2]), max_stall, tag);
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_sync  = 0;
        n_loss  = 0;
    endtask

    task automatic lock_pack(input int max_stall, input string tag);
        clear_counts();
        send_byte(SYNC, max_stall, tag);
        check_val({tag, ".lock_sync"}, 8'(n_sync), 8'd1);
        check_val({tag, ".lock_novalid"}, 8'(n_valid), 8'd0);
        check_val({tag, ".locked"}, 8'(locked), 8'd1);
        send_byte(8'h1B, max_stall, tag);
        check_val({tag, ".pack_valid"}, 8'(n_valid), 8'd1);
        check_val({tag, ".pack_data"}, data_out, 8'h1B);
        send_byte(SYNC, max_stall, tag);
        check_val({tag, ".resync"}, 8'(n_sync), 8'd2);
        check_val({tag, ".hold_data"}, data_out, 8'h1B);
        check_val({tag, ".no_extra_valid"}, 8'(n_valid), 8'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_L = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        #2 reset_L = 1'b1;
    endtask

    initial begin
        reset_L  = 1'b0;
        data_in  = 2'd0;
        valid_in = 1'b0;
        model_reset();
        clear_counts();

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) step(int'($urandom_range(0, 3)), 1'($urandom), "reset_hold");
        @(negedge clk);
        #2 reset_L = 1'b1;
        for (int i = 0; i < 3; i++) step(int'($urandom_range(0, 3)), 1'b0, "post_release");

        // Lock and pack, no stalls
        lock_pack(0, "lock_pack");

        // Sliding search after reset
        do_reset();
        clear_counts();
        send(1, 0, "slide"); send(1, 0, "slide"); send(2, 0, "slide");
        send(3, 0, "slide"); send(3, 0, "slide");
        check_val("slide.not_yet", 8'(locked), 8'd0);
        send(0, 0, "slide");
        check_val("slide.locked", 8'(locked), 8'd1);
        send_byte(8'hFF, 0, "slide");
        check_val("slide.data_ff", data_out, 8'hFF);

        // Gap loss
        do_reset();
        send_byte(SYNC, 0, "gap");
        clear_counts();
        for (int w = 0; w < 9; w++) send_byte(8'h01, 0, "gap");
        check_val("gap.valid_count", 8'(n_valid), 8'(MAX_GAP));
        check_val("gap.loss_count", 8'(n_loss), 8'd1);
        check_val("gap.loss_now", 8'(loss_pulse), 8'd1);
        check_val("gap.unlocked", 8'(locked), 8'd0);
        check_val("gap.data_kept", data_out, 8'h01);
        send_byte(SYNC, 0, "gap");
        check_val("gap.relock", 8'(locked), 8'd1);

        // Lock and pack with random stalls
        do_reset();
        lock_pack(3, "stall");

        // Async reset mid-word, then data without sync
        send(0, 0, "midword"); send(1, 0, "midword");
        @(negedge clk);
        #2 reset_L = 1'b0;
        #1;
        check_val("midword.locked_drop", 8'(locked), 8'd0);
        model_reset();
        check_outputs("midword_rst");
        @(negedge clk);
        #2 reset_L = 1'b1;
        clear_counts();
        for (int w = 0; w < 3; w++) send_byte(8'h1B, 0, "nosync");
        check_val("nosync.valid_count", 8'(n_valid), 8'd0);
        check_val("nosync.locked", 8'(locked), 8'd0);

        // Randomized traffic with sync words dropped in at arbitrary phase
        clear_counts();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 2) send_byte(SYNC, 2, "rand");
            else send(int'($urandom_range(0, 3)), 2, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sym2b_byte_packer.md
Name: sym2b_byte_packer

Overview:
- Downstream stage of the 2-bit 2:1 mux. Consumes the mux's registered 2-bit symbol stream, qualified by a valid strobe.
- Finds byte alignment by hunting for a sync word. Once aligned, packs four consecutive 2-bit symbols into one 8-bit word.
- Emits data words with a one-cycle valid pulse. Sync words are consumed internally and never emitted.
- Drops lock and re-hunts when no sync word has arrived within a programmable number of data words.

Parameters:
- SYNC_WORD, 8'hBC: alignment pattern. Must not be 8'h00.
- MAX_GAP, 8: maximum number of data words allowed between sync words before lock is lost. Range 1..255.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  2  symbol from the upstream mux (its data_out).
- valid_in  input  1  data_in is a valid symbol this cycle.
- data_out  output  8  last packed data word; held between pulses.
- valid_out  output  1  one-cycle pulse when data_out is updated.
- locked  output  1  high while in ALIGNED.
- sync_pulse  output  1  one-cycle pulse on each sync word detected (including the locking one).
- loss_pulse  output  1  one-cycle pulse when lock is dropped on gap timeout.

Behaviour:
- Reset (reset_L=0, asynchronous, takes effect immediately):
  - data_out=8'h00; valid_out, locked, sync_pulse, loss_pulse = 0.
  - shift=8'h00, sym_cnt=0, gap_cnt=0, state=SEARCH.
  - A reset mid-word discards the partial word. A fresh sync is required after release.
- valid_in=0: no internal state changes. Pulse outputs are 0. data_out holds.
- Bit order: the first symbol received lands in bits [7:6], the fourth in [1:0]. The next-shift value is {shift[5:0], data_in}.
- All outputs are registered. Latency: each response is visible the cycle after the clock edge that sampled the completing symbol.
- FSM state SEARCH (locked=0):
  - On each valid symbol, shift is updated with the next-shift value (sliding window).
  - If the next-shift value == SYNC_WORD: go to ALIGNED, sync_pulse=1, sym_cnt=0, gap_cnt=0. No valid_out.
- FSM state ALIGNED (locked=1):
  - On each valid symbol, shift is updated and sym_cnt increments modulo 4.
  - A word completes on the symbol where sym_cnt==3. The completed word is W = next-shift value.
  - W == SYNC_WORD: sync_pulse=1, gap_cnt=0, no valid_out.
  - W != SYNC_WORD and gap_cnt < MAX_GAP: data_out=W, valid_out=1, gap_cnt+1.
  - W != SYNC_WORD and gap_cnt == MAX_GAP: W is discarded, loss_pulse=1, shift=8'h00, gap_cnt=0, state=SEARCH.
- A non-aligned pattern equal to SYNC_WORD inside ALIGNED is ordinary data. Only word-boundary matches count.
- sync_pulse, valid_out and loss_pulse are mutually exclusive in any cycle.
- gap_cnt saturates logically at MAX_GAP and never wraps.

Test Plan:
- Reset: hold reset_L=0 with random data_in/valid_in -> data_out=8'h00; locked, valid_out, sync_pulse, loss_pulse all 0. Deassert reset_L mid-cycle -> outputs unchanged until valid symbols arrive.
- Lock + pack: symbols 2,3,3,0 -> one sync_pulse, locked=1, no valid_out. Then 0,1,2,3 -> valid_out pulse with data_out=8'h1B. Then 2,3,3,0 -> sync_pulse only; data_out stays 8'h1B.
- Sliding search: symbols 1,1,2,3,3,0 -> lock on the 6th symbol. Next symbols 3,3,3,3 -> data_out=8'hFF.
- Gap loss (MAX_GAP=8): after lock, send 9 words of 8'h01 -> exactly 8 valid_out pulses. On the 9th word: loss_pulse=1, locked=0, data_out remains 8'h01. Then 2,3,3,0 -> relock.
- Stalls: repeat the lock + pack stimulus with 0–3 random valid_in=0 cycles between symbols -> identical outputs, with each pulse aligned to its completing symbol.
- Async reset mid-word: after lock, send 2 symbols, pull reset_L low between clock edges -> locked drops immediately, before the next edge. After release, data symbols without a sync produce no valid_out.
